bit_reverse_reorder: RTL
========================

BIT_REVERSE_REORDER -- requirements
Module: bit_reverse_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning sample width in bits.
REQ-002 SHALL have parameter LOG2N, default 3, meaning log2 of frame length N (N = 2**LOG2N, LOG2N >= 1).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, input sample valid.
REQ-006 SHALL have port in_data, input, DATA_W bits, input sample.
REQ-007 SHALL have port in_ready, output, 1 bit, block can accept a sample.
REQ-008 SHALL have port out_valid, output, 1 bit, output sample valid.
REQ-009 SHALL have port out_data, output, DATA_W bits, output sample.
REQ-010 SHALL have port out_last, output, 1 bit, marks the final sample of an output frame.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts the output sample.

Function
REQ-012 SHALL reorder each frame of N input samples so that output position k carries input sample bitrev(k), where bitrev mirrors bit i to bit LOG2N-1-i.
REQ-013 SHALL hold two banks of N x DATA_W registers (ping-pong); each bank has state EMPTY or FULL.
REQ-014 SHALL keep write pointer wbank, read pointer rbank and counters wcnt and rcnt, each LOG2N bits wide.
REQ-015 SHALL accept an input transfer when in_valid && in_ready; a transfer writes in_data to bank[wbank][wcnt] and increments wcnt.
REQ-016 SHALL drive in_ready = 1 exactly when bank[wbank] is EMPTY.
REQ-017 SHALL, on the transfer with wcnt == N-1, set bank[wbank] FULL, wrap wcnt to 0 and toggle wbank.
REQ-018 SHALL drive out_valid = 1 exactly when bank[rbank] is FULL.
REQ-019 SHALL drive out_data = bank[rbank][bitrev(rcnt)] combinationally from the registers.
REQ-020 SHALL drive out_last = out_valid && (rcnt == N-1).
REQ-021 SHALL complete an output transfer when out_valid && out_ready; the transfer increments rcnt.
REQ-022 SHALL, on the output transfer with rcnt == N-1, set bank[rbank] EMPTY, wrap rcnt to 0 and toggle rbank.
REQ-023 SHALL hold out_data and out_last stable while out_valid && !out_ready.
REQ-024 SHALL assert out_valid for a frame on the cycle after that frame's last input transfer (latency 1 cycle).
REQ-025 SHALL allow, in the same cycle, one bank to go FULL (write side) and the other bank to go EMPTY (read side); both updates take effect.
REQ-026 SHALL sustain 1 sample/cycle in and out with no bubbles when in_valid and out_ready are held high, after the first-frame latency.
REQ-027 SHALL drive in_ready = 0 when both banks are FULL, and ignore in_data in that state; no overwrite of a FULL bank.
REQ-028 SHALL drop no sample and duplicate no sample across frame boundaries or back-pressure.

Reset
REQ-029 SHALL, while rst = 1, force both banks EMPTY, wbank = rbank = 0, wcnt = rcnt = 0, in_ready = 1, out_valid = 0, out_last = 0.
REQ-030 SHALL discard any partial or unread frame on reset mid-operation; the first input accepted after rst falls is sample 0 of a new frame.
REQ-031 SHALL leave bank data contents unspecified after reset; out_data is don't-care while out_valid = 0.

Verification
REQ-032 SHALL cover single frame, N=8, in_data 0..7 one per cycle, out_ready = 1 -> out_data 0,4,2,6,1,5,3,7; out_last only on 7; out_valid rises the cycle after input 7.
REQ-033 SHALL cover streaming, 4 back-to-back frames (values 0..31), out_ready = 1 -> in_ready never drops; each frame is bit-reversed within itself, in frame order.
REQ-034 SHALL cover back-pressure, out_ready = 0 while 2 frames are written -> in_ready drops after 16 accepts. Raising out_ready then drains both frames in order, and in_ready returns 1 the cycle after the first out_last transfer.
REQ-035 SHALL cover output stall, out_ready toggling every cycle mid-frame -> out_data and out_last are held while stalled; the sequence is unchanged.
REQ-036 SHALL cover reset mid-operation: rst pulsed after 5 inputs of frame 2 while frame 1 is half read. Required: out_valid = 0 and in_ready = 1 immediately (asynchronous). A new frame 8..15 then yields 8,12,10,14,9,13,11,15.
REQ-037 SHALL cover LOG2N = 1 (N = 2), inputs A,B -> outputs A,B with out_last on B.

Source files
------------

// File: rtl/bit_reverse_reorder.sv
// Ping-pong frame buffer that emits each N-sample frame in bit-reversed order.
// One bank fills while the other drains, so steady-state throughput is 1/cycle.
module bit_reverse_reorder #(
  parameter int DATA_W = 8,
  parameter int LOG2N  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] ONE = 1;

  logic [DATA_W-1:0] mem_q [2][N];
  logic [1:0]        full_q, full_d;
  logic              wbank_q, wbank_d;
  logic              rbank_q, rbank_d;
  logic [LOG2N-1:0]  wcnt_q, wcnt_d;
  logic [LOG2N-1:0]  rcnt_q, rcnt_d;
  logic [LOG2N-1:0]  raddr;
  logic              wr_en, rd_en;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] v
  );
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++)
      r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready  = !full_q[wbank_q];
  assign out_valid = full_q[rbank_q];
  assign raddr     = bitrev(rcnt_q);
  assign out_data  = mem_q[rbank_q][raddr];
  assign out_last  = out_valid && (rcnt_q == '1);
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;

  // Write and read sides always target different banks when both
  // complete a frame, so both full-flag updates land together.
  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    if (wr_en) begin
      wcnt_d = wcnt_q + ONE;
      if (wcnt_q == '1) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    if (rd_en) begin
      rcnt_d = rcnt_q + ONE;
      if (rcnt_q == '1) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = ~rbank_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Sample storage needs no reset; contents are only visible when FULL.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wbank_q][wcnt_q] <= in_data;
  end

endmodule
